alt_vipcti121_common_handshake_tx: RTL

Source-side end of the toggle request/acknowledge clock-domain crossing used by the clocked-video-input path. It accepts words on a valid/ready stream, holds each word stable on `data_out`, and flips `req_toggle` to announce it. It then waits for the destination domain's `ack_toggle` to match, re-timing it internally through a two-flop synchronizer. The destination side samples `req_toggle` through its own two-flop synchronizer and captures `data_out` once the toggle is seen.

---
 rtl/alt_vipcti121_common_handshake_tx.sv | 127 ++++++++++++
 1 files changed

// File: rtl/alt_vipcti121_common_handshake_tx.sv
// Source side of a toggle req/ack clock-domain crossing: holds each accepted word on data_out
// and flips req_toggle until the re-synchronized ack_toggle matches. Optional skid: ALT_VIPCTI_HSTX_SKID_EN.
module alt_vipcti121_common_handshake_tx #(
  parameter int WIDTH       = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic [WIDTH-1:0]       data_out,
  output logic                   req_toggle,
  input  logic                   ack_toggle,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] xfer_count,
  output logic                   proto_err
);

  typedef enum logic {IDLE, WAIT_ACK} state_t;

  state_t                 state, state_nxt;
  logic                   ack_s1, ack_s2;
  logic                   err_q;
  logic                   ack_match, accept;
  logic [WIDTH-1:0]       data_nxt;
  logic                   req_nxt;
  logic [COUNT_WIDTH-1:0] cnt_nxt;

  assign ack_match = (ack_s2 == req_toggle);
  // The live term lets the error block acceptance on the cycle it is first seen.
  assign proto_err = err_q | ((state == IDLE) & ~ack_match);
  assign accept    = in_valid & in_ready;

`ifdef ALT_VIPCTI_HSTX_SKID_EN
  logic             skid_full, skid_full_nxt;
  logic [WIDTH-1:0] skid_data, skid_data_nxt;

  assign in_ready = ~skid_full & ~proto_err;
  assign busy     = (state == WAIT_ACK) | skid_full;
`else
  assign in_ready = (state == IDLE) & ~proto_err;
  assign busy     = (state == WAIT_ACK);
`endif

  always_comb begin
    state_nxt = state;
    data_nxt  = data_out;
    req_nxt   = req_toggle;
    cnt_nxt   = xfer_count;
`ifdef ALT_VIPCTI_HSTX_SKID_EN
    skid_full_nxt = skid_full;
    skid_data_nxt = skid_data;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          data_nxt  = in_data;
          req_nxt   = ~req_toggle;
          state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
`ifdef ALT_VIPCTI_HSTX_SKID_EN
        if (accept) begin
          skid_full_nxt = 1'b1;
          skid_data_nxt = in_data;
        end
        if (ack_match) begin
          cnt_nxt = xfer_count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
          // Chain the next word straight onto the link instead of passing through IDLE.
          if (skid_full) begin
            data_nxt      = skid_data;
            req_nxt       = ~req_toggle;
            skid_full_nxt = 1'b0;
          end else if (accept) begin
            data_nxt      = in_data;
            req_nxt       = ~req_toggle;
            skid_full_nxt = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end
`else
        if (ack_match) begin
          cnt_nxt   = xfer_count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
          state_nxt = IDLE;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ack_s1     <= 1'b0;
      ack_s2     <= 1'b0;
      err_q      <= 1'b0;
      data_out   <= '0;
      req_toggle <= 1'b0;
      xfer_count <= '0;
    end else begin
      ack_s1     <= ack_toggle;
      ack_s2     <= ack_s1;
      err_q      <= proto_err;
      state      <= state_nxt;
      data_out   <= data_nxt;
      req_toggle <= req_nxt;
      xfer_count <= cnt_nxt;
    end
  end

`ifdef ALT_VIPCTI_HSTX_SKID_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_full <= 1'b0;
      skid_data <= '0;
    end else begin
      skid_full <= skid_full_nxt;
      skid_data <= skid_data_nxt;
    end
  end
`endif

endmodule
